// File: rtl/cluster_boot_seq_pkg.sv
// rtl/cluster_boot_seq_pkg.sv - shared types and helpers for the cluster boot sequencer
package cluster_boot_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REQ,
        ST_RSP,
        ST_IRQ,
        ST_ERROR
    } state_e;

    // Bit position of core `core` of cluster `cluster` within the flat msip vector
    function automatic int unsigned msip_idx(input int unsigned cluster,
                                             input int unsigned core,
                                             input int unsigned nr_cores);
        return cluster * nr_cores + core;
    endfunction

endpackage

// File: rtl/cluster_boot_seq_timer.sv
// rtl/cluster_boot_seq_timer.sv - loadable down-counter shared by the delay and irq-hold phases
module cluster_boot_seq_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expired_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Load wins over decrement; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expired one count early so the owning state leaves on the edge the count reaches zero
    assign expired_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/cluster_boot_seq.sv
// rtl/cluster_boot_seq.sv - boots every cluster via scratch writes then pulses msip (option: CLUSTER_BOOT_SEQ_RETRY_EN)
module cluster_boot_seq
    import cluster_boot_seq_pkg::*;
#(
    parameter int unsigned          NrClusters    = 2,
    parameter int unsigned          NrCores       = 9,
    parameter int unsigned          AddrWidth     = 48,
    parameter int unsigned          DataWidth     = 32,
    parameter logic [AddrWidth-1:0] ClusterStride = AddrWidth'('h40000),
    parameter logic [AddrWidth-1:0] ScratchOffset = AddrWidth'('h180),
    parameter int unsigned          BootDelay     = 1000,
    parameter int unsigned          IrqHold       = 16
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
    ,
    parameter int unsigned          MaxRetries    = 3
`endif
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          start_i,
    input  logic [AddrWidth-1:0]          base_addr_i,
    input  logic [DataWidth-1:0]          entry_point_i,
    output logic                          req_valid_o,
    input  logic                          req_ready_i,
    output logic [AddrWidth-1:0]          req_addr_o,
    output logic [DataWidth-1:0]          req_data_o,
    input  logic                          rsp_valid_i,
    input  logic                          rsp_error_i,
    output logic [NrClusters*NrCores-1:0] msip_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o
);

    localparam int unsigned TimerMax   = (BootDelay > IrqHold) ? BootDelay : IrqHold;
    localparam int unsigned TimerWidth = $clog2(TimerMax + 1);
    localparam int unsigned IdxWidth   = (NrClusters > 1) ? $clog2(NrClusters) : 1;
    localparam int unsigned MsipWidth  = NrClusters * NrCores;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NrClusters - 1);

    function automatic logic [MsipWidth-1:0] all_msip();
        logic [MsipWidth-1:0] m;
        m = '0;
        for (int unsigned c = 0; c < NrClusters; c++) begin
            for (int unsigned k = 0; k < NrCores; k++) begin
                m = m | (MsipWidth'(1) << msip_idx(c, k, NrCores));
            end
        end
        return m;
    endfunction

    localparam logic [MsipWidth-1:0] MsipAll = all_msip();

    // Scratch register address of a cluster; wraps modulo 2^AddrWidth
    function automatic logic [AddrWidth-1:0] scratch_addr(input logic [AddrWidth-1:0] base,
                                                          input logic [IdxWidth-1:0]  idx);
        return base + AddrWidth'(idx) * ClusterStride + ScratchOffset;
    endfunction

    state_e                 state_q;
    logic [AddrWidth-1:0]   base_q;
    logic [DataWidth-1:0]   entry_q;
    logic [IdxWidth-1:0]    idx_q;
    logic [IdxWidth-1:0]    idx_inc;
    logic                   req_valid_q;
    logic [AddrWidth-1:0]   req_addr_q;
    logic [MsipWidth-1:0]   msip_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;

    logic                   tmr_load;
    logic [TimerWidth-1:0]  tmr_val;
    logic                   tmr_dec;
    logic                   tmr_expired;

`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
    localparam int unsigned RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    logic [RetryWidth-1:0]  retry_q;
`endif

    assign idx_inc = idx_q + 1'b1;

    // Timer is loaded on start and on the last good response, counted down in Delay and Irq
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tmr_load = 1'b1;
                    tmr_val  = TimerWidth'(BootDelay);
                end
            end
            ST_DELAY, ST_IRQ: tmr_dec = 1'b1;
            ST_RSP: begin
                if (rsp_valid_i && !rsp_error_i && (idx_q == LastIdx)) begin
                    tmr_load = 1'b1;
                    tmr_val  = TimerWidth'(IrqHold);
                end
            end
            default: ;
        endcase
    end

    cluster_boot_seq_timer #(
        .Width (TimerWidth)
    ) i_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_expired)
    );

    // Sequencer FSM with all outputs registered alongside the state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            entry_q     <= '0;
            idx_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            msip_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
            retry_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q     <= base_addr_i;
                        entry_q    <= entry_point_i;
                        idx_q      <= '0;
                        req_addr_q <= scratch_addr(base_addr_i, '0);
                        error_q    <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
                        retry_q    <= '0;
`endif
                        if (BootDelay == 0) begin
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end else begin
                            state_q     <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (tmr_expired) begin
                        req_valid_q <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_ready_i) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_valid_i) begin
                        if (!rsp_error_i) begin
                            if (idx_q == LastIdx) begin
                                msip_q  <= MsipAll;
                                state_q <= ST_IRQ;
                            end else begin
                                idx_q       <= idx_inc;
                                req_addr_q  <= scratch_addr(base_q, idx_inc);
                                req_valid_q <= 1'b1;
                                state_q     <= ST_REQ;
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
                                retry_q     <= '0;
`endif
                            end
                        end
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
                        else if (retry_q < RetryWidth'(MaxRetries)) begin
                            retry_q     <= retry_q + 1'b1;
                            req_valid_q <= 1'b1;
                            state_q     <= ST_REQ;
                        end
`endif
                        else begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_ERROR;
                        end
                    end
                end
                ST_IRQ: begin
                    if (tmr_expired) begin
                        msip_q  <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ERROR: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_addr_o  = req_addr_q;
    assign req_data_o  = entry_q;
    assign msip_o      = msip_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;

endmodule

// File: tb/tb_cluster_boot_seq.sv
// tb/tb_cluster_boot_seq.sv - table-driven bench for cluster_boot_seq (both CLUSTER_BOOT_SEQ_RETRY_EN builds)
module tb_cluster_boot_seq;

    localparam int unsigned NC   = 2;
    localparam int unsigned NCOR = 9;
    localparam int unsigned AW   = 48;
    localparam int unsigned DW   = 32;
    localparam int unsigned D    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned MW   = NC * NCOR;
    localparam logic [MW-1:0] MSIP_ALL = '1;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [DW-1:0] entry_point_i = '0;
    logic          req_valid_o;
    logic          req_ready_i = 1'b1;
    logic [AW-1:0] req_addr_o;
    logic [DW-1:0] req_data_o;
    logic          rsp_valid_i = 1'b0;
    logic          rsp_error_i = 1'b0;
    logic [MW-1:0] msip_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cluster_boot_seq #(
        .NrClusters (NC),
        .NrCores    (NCOR),
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .BootDelay  (D),
        .IrqHold    (H)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .entry_point_i (entry_point_i),
        .req_valid_o   (req_valid_o),
        .req_ready_i   (req_ready_i),
        .req_addr_o    (req_addr_o),
        .req_data_o    (req_data_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_error_i   (rsp_error_i),
        .msip_o        (msip_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o)
    );

    typedef struct {
        string         name;
        logic [AW-1:0] base;
        logic [DW-1:0] entry;
        int            stall;
        logic [7:0]    err_mask;
        bit            inject;
        int            exp_n;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            exp_msip;
        int            exp_done;
        bit            exp_err;
    } vec_t;

    typedef struct {
        int            n;
        logic [AW-1:0] a_first;
        logic [AW-1:0] a_last;
        bit            data_ok;
        bit            stable_ok;
        int            first_req;
        bit            busy1;
        bit            err1;
        int            msip_cyc;
        bit            msip_bad;
        int            done_cnt;
        int            done_gap;
        bit            msip_at_done;
        bit            err_final;
        bit            busy_final;
        int            extra;
        bit            timeout;
        bit            did_rst;
        logic [MW-1:0] rst_msip;
        bit            rst_busy;
        bit            rst_valid;
    } res_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One start plus responder; sample k at negedge k reflects the value seen at edge start+k
    task automatic run_seq(input vec_t v, input bit rst_in_irq, output res_t r);
        int stall_left;
        bit pend;
        bit prev_hold;
        bit seen_req;
        logic [AW-1:0] prev_a;
        logic [DW-1:0] prev_d;
        int last_rsp_k;
        int end_k;
        stall_left = v.stall; pend = 0; prev_hold = 0; seen_req = 0;
        prev_a = '0; prev_d = '0; last_rsp_k = -100; end_k = -1;
        r.n = 0; r.a_first = '0; r.a_last = '0; r.data_ok = 1; r.stable_ok = 1;
        r.first_req = -1; r.busy1 = 0; r.err1 = 0; r.msip_cyc = 0; r.msip_bad = 0;
        r.done_cnt = 0; r.done_gap = -1; r.msip_at_done = 0; r.err_final = 0;
        r.busy_final = 0; r.extra = 0; r.timeout = 0; r.did_rst = 0;
        r.rst_msip = '1; r.rst_busy = 1; r.rst_valid = 1;
        @(negedge clk);
        start_i = 1; base_addr_i = v.base; entry_point_i = v.entry; req_ready_i = 1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start_i = 0; rsp_valid_i = 0; rsp_error_i = 0; req_ready_i = 1;
            if (k == 1) begin r.busy1 = busy_o; r.err1 = error_o; end
            if (v.inject && k == 2) begin start_i = 1; base_addr_i = ~v.base; end
            if (prev_hold && (!req_valid_o || req_addr_o !== prev_a || req_data_o !== prev_d))
                r.stable_ok = 0;
            prev_hold = 0;
            if (end_k >= 0) begin
                if (req_valid_o) r.extra++;
            end else if (req_valid_o) begin
                if (!seen_req) begin seen_req = 1; r.first_req = k; end
                if (stall_left > 0) begin
                    stall_left--; req_ready_i = 0; prev_hold = 1;
                    prev_a = req_addr_o; prev_d = req_data_o;
                end else begin
                    if (r.n == 0) r.a_first = req_addr_o;
                    r.a_last = req_addr_o;
                    if (req_data_o !== v.entry) r.data_ok = 0;
                    r.n++; pend = 1;
                end
                if (v.inject) begin rsp_valid_i = 1; rsp_error_i = 1; end
            end else if (pend) begin
                rsp_valid_i = 1; rsp_error_i = v.err_mask[r.n-1]; pend = 0; last_rsp_k = k;
            end
            if (msip_o === MSIP_ALL) r.msip_cyc++;
            else if (msip_o !== '0) r.msip_bad = 1;
            if (done_o) begin
                r.done_cnt++; r.msip_at_done = |msip_o;
                if (r.done_cnt == 1) r.done_gap = k - last_rsp_k;
            end
            if (rst_in_irq && msip_o === MSIP_ALL) begin
                #2 rst_i = 1;
                #1 r.rst_msip = msip_o; r.rst_busy = busy_o; r.rst_valid = req_valid_o;
                r.did_rst = 1;
                @(negedge clk);
                rst_i = 0;
                break;
            end
            if (end_k < 0 && (done_o || (error_o && !busy_o))) end_k = k;
            if (end_k >= 0 && k >= end_k + 4) break;
        end
        r.timeout = (end_k < 0) && !r.did_rst;
        r.err_final = error_o; r.busy_final = busy_o;
        rsp_valid_i = 0; rsp_error_i = 0; start_i = 0; req_ready_i = 1;
    endtask

    task automatic check_run(input vec_t v, input res_t r);
        chk({v.name, " timeout"}, r.timeout, 0);
        chk({v.name, " busy_at_start+1"}, r.busy1, 1);
        chk({v.name, " error_cleared_by_start"}, r.err1, 0);
        chk({v.name, " first_req_cycle"}, r.first_req, 1 + D);
        chk({v.name, " write_count"}, r.n, v.exp_n);
        chk({v.name, " first_addr"}, r.a_first, v.exp_first);
        chk({v.name, " last_addr"}, r.a_last, v.exp_last);
        chk({v.name, " data_is_entry"}, r.data_ok, 1);
        chk({v.name, " req_stable"}, r.stable_ok, 1);
        chk({v.name, " msip_cycles"}, r.msip_cyc, v.exp_msip);
        chk({v.name, " msip_partial"}, r.msip_bad, 0);
        chk({v.name, " done_count"}, r.done_cnt, v.exp_done);
        chk({v.name, " error_final"}, r.err_final, v.exp_err);
        chk({v.name, " busy_final"}, r.busy_final, 0);
        chk({v.name, " extra_writes"}, r.extra, 0);
        if (v.exp_done == 1) begin
            chk({v.name, " done_after_last_rsp"}, r.done_gap, H + 1);
            chk({v.name, " msip_low_at_done"}, r.msip_at_done, 0);
        end
    endtask

    vec_t vecs[$];
    vec_t v_nom;
    res_t r;
    int   stray;

    initial begin
        v_nom = '{"nominal", 48'h0000_1000_0000, 32'h8000_0000, 0, 8'h00, 0,
                  2, 48'h0000_1000_0180, 48'h0000_1004_0180, H, 1, 0};
        vecs.push_back(v_nom);
        vecs.push_back('{"backpressure", 48'h0000_2000_0000, 32'h8000_1000, 7, 8'h00, 0,
                         2, 48'h0000_2000_0180, 48'h0000_2004_0180, H, 1, 0});
        vecs.push_back('{"addr_wrap", 48'hFFFF_FFFF_FE00, 32'h1234_5678, 0, 8'h00, 0,
                         2, 48'hFFFF_FFFF_FF80, 48'h0000_0003_FF80, H, 1, 0});
        vecs.push_back('{"ignored_inputs", 48'h0000_1000_0000, 32'h8000_0000, 2, 8'h00, 1,
                         2, 48'h0000_1000_0180, 48'h0000_1004_0180, H, 1, 0});
`ifdef CLUSTER_BOOT_SEQ_RETRY_EN
        vecs.push_back('{"retry_cl1", 48'h0000_1000_0000, 32'h8000_0000, 0, 8'b0110, 0,
                         4, 48'h0000_1000_0180, 48'h0000_1004_0180, H, 1, 0});
        vecs.push_back('{"retry_exhausted_cl0", 48'h0000_1000_0000, 32'h8000_0000, 0, 8'b1111, 0,
                         4, 48'h0000_1000_0180, 48'h0000_1000_0180, 0, 0, 1});
`else
        vecs.push_back('{"error_cl1", 48'h0000_1000_0000, 32'h8000_0000, 0, 8'b0010, 0,
                         2, 48'h0000_1000_0180, 48'h0000_1004_0180, 0, 0, 1});
`endif
        vecs.push_back('{"after_error", 48'h0000_3000_0000, 32'h9000_0000, 0, 8'h00, 0,
                         2, 48'h0000_3000_0180, 48'h0000_3004_0180, H, 1, 0});

        // Reset values, both during and after reset
        #1;
        chk("reset_outputs", {req_valid_o, busy_o, done_o, error_o, msip_o, req_addr_o}, '0);
        @(negedge clk);
        @(negedge clk);
        rst_i = 0;
        @(negedge clk);
        chk("post_reset_outputs", {req_valid_o, busy_o, done_o, error_o, msip_o, req_addr_o}, '0);

        foreach (vecs[i]) begin
            run_seq(vecs[i], 0, r);
            check_run(vecs[i], r);
            repeat (2) @(negedge clk);
        end

        // Asynchronous reset while msip is asserted
        run_seq(v_nom, 1, r);
        chk("rst_irq reached", r.did_rst, 1);
        chk("rst_irq writes", r.n, 2);
        chk("rst_irq msip", r.rst_msip, '0);
        chk("rst_irq busy", r.rst_busy, 0);
        chk("rst_irq req_valid", r.rst_valid, 0);
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (req_valid_o || busy_o || error_o || done_o || (msip_o !== '0)) stray++;
        end
        chk("rst_irq quiet_after", stray, 0);
        run_seq(v_nom, 0, r);
        check_run('{"after_reset", v_nom.base, v_nom.entry, 0, 8'h00, 0,
                    2, v_nom.exp_first, v_nom.exp_last, H, 1, 0}, r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
